// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: instruction-memory responder for the fetch stage.
// Returns the word addressed by pc_addr after WAIT_CYCLES wait states, stalls
// the PC through PC_Write while a fetch is outstanding, aborts on flush, and
// offers a preload write port.
// Ports:
//   clk, rst (async, active-low)
//   pc_addr, fetch_req, flush           fetch-side request and redirect
//   load_en, load_addr, load_data       preload write port
//   instr, instr_valid, fault, PC_Write response and PC enable
module imem_fetch_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    pc_addr,
    input  logic                           fetch_req,
    input  logic                           flush,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data,
    output logic [31:0]                    instr,
    output logic                           instr_valid,
    output logic                           fault,
    output logic                           PC_Write
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic          accept, bad_addr, fault_q;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH_WORDS];

    assign idx      = pc_addr[AW+1:2];
    assign bad_addr = (|pc_addr[1:0]) | (|pc_addr[31:AW+2]);

    // A flush lets a new request in from any state, redirecting the fetch.
    always_comb begin
        accept   = fetch_req & (flush | (state != WAIT));
        state_nx = state;
        cnt_nx   = cnt;
        if (accept) begin
            state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
            cnt_nx   = CNT_INIT;
        end else if (flush) begin
            state_nx = IDLE;
        end else if (state == WAIT) begin
            state_nx = (cnt == 4'd0) ? RESP : WAIT;
            cnt_nx   = (cnt == 4'd0) ? cnt : cnt - 4'd1;
        end else if (state == RESP) begin
            state_nx = IDLE;
        end
    end

    // Data is captured at acceptance, so later preloads never reach an
    // accepted fetch; a same-edge write is seen only by later fetches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            instr   <= NOP_INSTR;
            fault_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                instr   <= bad_addr ? NOP_INSTR : mem[idx];
                fault_q <= bad_addr;
            end else if (flush) begin
                instr   <= NOP_INSTR;
                fault_q <= 1'b0;
            end
        end
    end

    // Memory is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
    end

    assign instr_valid = (state == RESP) & ~flush;
    assign fault       = instr_valid & fault_q;
    assign PC_Write    = (state == RESP) | ((state == IDLE) & (~fetch_req | flush));
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: directed bench for imem_fetch_responder (WAIT=2 and WAIT=0 builds).
module tb_imem_fetch_responder;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr, pc_addr0;
    logic        fetch_req, fetch_req0, flush;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] instr, instr0;
    logic        instr_valid, instr_valid0, fault, fault0, pc_write, pc_write0;
    logic        flush0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] words [4];

    imem_fetch_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .fetch_req(fetch_req), .flush(flush),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .instr(instr), .instr_valid(instr_valid), .fault(fault), .PC_Write(pc_write)
    );

    imem_fetch_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .pc_addr(pc_addr0), .fetch_req(fetch_req0), .flush(flush0),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .instr(instr0), .instr_valid(instr_valid0), .fault(fault0), .PC_Write(pc_write0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        words[0] = 32'h0050_0093;
        words[1] = 32'h00A0_0113;
        words[2] = 32'h0020_81B3;
        words[3] = 32'h0000_0013;
        rst = 1'b0; pc_addr = '0; pc_addr0 = '0; fetch_req = 1'b0; fetch_req0 = 1'b0;
        flush = 1'b0; flush0 = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        tick(); tick();
        chk("rst_instr", instr, NOP);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_pcw", {31'd0, pc_write}, 32'd1);
        chk("rst_instr0", instr0, NOP);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            load_en = 1'b1; load_addr = 8'(i); load_data = words[i];
            tick();
        end
        load_en = 1'b0;

        // single fetch with two wait states
        fetch_req = 1'b1; pc_addr = 32'd0; #1;
        chk("t1_pcw_req", {31'd0, pc_write}, 32'd0);
        tick();
        fetch_req = 1'b0; #1;
        chk("t1_valid_w0", {31'd0, instr_valid}, 32'd0);
        chk("t1_pcw_w0", {31'd0, pc_write}, 32'd0);
        tick();
        chk("t1_valid_w1", {31'd0, instr_valid}, 32'd0);
        chk("t1_pcw_w1", {31'd0, pc_write}, 32'd0);
        tick();
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_instr", instr, 32'h0050_0093);
        chk("t1_fault", {31'd0, fault}, 32'd0);
        chk("t1_pcw", {31'd0, pc_write}, 32'd1);
        tick();
        chk("t1_valid_after", {31'd0, instr_valid}, 32'd0);

        // back-to-back fetches of words 0,1,2
        fetch_req = 1'b1; pc_addr = 32'd0;
        tick();
        for (int j = 0; j < 3; j++) begin
            chk("b2b_gap0", {31'd0, instr_valid}, 32'd0);
            tick();
            chk("b2b_gap1", {31'd0, instr_valid}, 32'd0);
            tick();
            chk("b2b_valid", {31'd0, instr_valid}, 32'd1);
            chk("b2b_instr", instr, words[j]);
            chk("b2b_fault", {31'd0, fault}, 32'd0);
            pc_addr = 32'(4 * (j + 1));
            if (j == 2) fetch_req = 1'b0;
            tick();
        end
        chk("b2b_idle", {31'd0, instr_valid}, 32'd0);

        // flush redirect during WAIT
        fetch_req = 1'b1; pc_addr = 32'd4;
        tick();
        flush = 1'b1; pc_addr = 32'd12; #1;
        chk("fl_valid_now", {31'd0, instr_valid}, 32'd0);
        tick();
        flush = 1'b0; fetch_req = 1'b0; #1;
        chk("fl_valid_1", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("fl_valid_2", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("fl_valid", {31'd0, instr_valid}, 32'd1);
        chk("fl_instr", instr, 32'h0000_0013);
        tick();

        // flush in RESP suppresses that cycle's pulse
        fetch_req = 1'b1; pc_addr = 32'd8;
        tick();
        fetch_req = 1'b0;
        tick(); tick();
        flush = 1'b1; #1;
        chk("flr_valid", {31'd0, instr_valid}, 32'd0);
        chk("flr_fault", {31'd0, fault}, 32'd0);
        tick();
        flush = 1'b0; #1;
        chk("flr_after", {31'd0, instr_valid}, 32'd0);

        // misaligned and out-of-range faults
        fetch_req = 1'b1; pc_addr = 32'h0000_0006;
        tick();
        fetch_req = 1'b0;
        tick(); tick();
        chk("mis_valid", {31'd0, instr_valid}, 32'd1);
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_instr", instr, NOP);
        tick();
        fetch_req = 1'b1; pc_addr = 32'h0000_0400;
        tick();
        fetch_req = 1'b0;
        tick(); tick();
        chk("oor_valid", {31'd0, instr_valid}, 32'd1);
        chk("oor_fault", {31'd0, fault}, 32'd1);
        chk("oor_instr", instr, NOP);
        tick();
        chk("oor_fault_off", {31'd0, fault}, 32'd0);

        // reset in the middle of a WAIT
        fetch_req = 1'b1; pc_addr = 32'd8;
        tick();
        fetch_req = 1'b0; rst = 1'b0; #1;
        chk("rw_instr", instr, NOP);
        chk("rw_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rw_no_valid", {31'd0, instr_valid}, 32'd0);
        end
        fetch_req = 1'b1; pc_addr = 32'd8;
        tick();
        fetch_req = 1'b0;
        tick(); tick();
        chk("rw_mem_valid", {31'd0, instr_valid}, 32'd1);
        chk("rw_mem_instr", instr, 32'h0020_81B3);
        tick();

        // zero-wait build: one response per cycle
        fetch_req0 = 1'b1; pc_addr0 = 32'd0;
        tick();
        for (int j = 0; j < 3; j++) begin
            chk("z_valid", {31'd0, instr_valid0}, 32'd1);
            chk("z_instr", instr0, words[j]);
            chk("z_pcw", {31'd0, pc_write0}, 32'd1);
            pc_addr0 = 32'(4 * (j + 1));
            if (j == 2) begin
                load_en = 1'b1; load_addr = 8'd3; load_data = 32'hDEAD_BEEF;
            end
            tick();
        end
        load_en = 1'b0; #1;
        chk("z_same_edge_old", instr0, 32'h0000_0013);
        tick();
        chk("z_new_data", instr0, 32'hDEAD_BEEF);
        fetch_req0 = 1'b0;
        tick();
        chk("z_idle", {31'd0, instr_valid0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
